ultra_sonic_responder: RTL and testbench

// Emulates an HC-SR04-style ultrasonic sensor: accepts the trigger pulse from the

---
 rtl/ultra_sonic_responder.sv | 155 +++++++++++++++
 tb/tb_ultra_sonic_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ultra_sonic_responder.sv
// HC-SR04 style ultrasonic sensor emulator: qualifies a trigger pulse and answers
// with an echo pulse whose width comes from a programmable length register.
module ultra_sonic_responder #(
  parameter int MIN_TRIG_CYCLES    = 500,
  parameter int BURST_DELAY_CYCLES = 10000,
  parameter int MAX_ECHO_CYCLES    = 1900000,
  parameter int HOLDOFF_CYCLES     = 500000,
  parameter int DEFAULT_ECHO       = 29000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  output logic        echo,
  input  logic        cfg_write,
  input  logic [31:0] cfg_data,
  output logic [31:0] cfg_echo_len,
  output logic        busy,
  output logic        trig_error,
  output logic [15:0] echo_count
);

  localparam int TRIG_W = $clog2(MIN_TRIG_CYCLES + 1);
  localparam int DLY_W  = $clog2(BURST_DELAY_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [TRIG_W-1:0] TRIG_MIN  = TRIG_W'(MIN_TRIG_CYCLES);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(BURST_DELAY_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    ECHO    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              trig_m, trig_s, trig_d;
  logic              trig_fall;
  logic [TRIG_W-1:0] trig_cnt;
  logic              trig_ok;
  logic [DLY_W-1:0]  dly_cnt;
  logic              dly_done;
  logic [31:0]       echo_cnt;
  logic [31:0]       shadow_len;
  logic              echo_done;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              accept;
  logic              reject;

  // Trigger length counter stops at the threshold so it never wraps on long pulses.
  function automatic logic [TRIG_W-1:0] trig_sat_inc(input logic [TRIG_W-1:0] cnt);
    return (cnt >= TRIG_MIN) ? TRIG_MIN : cnt + TRIG_W'(1);
  endfunction

  // A programmed length of zero means "no object": the longest echo.
  function automatic logic [31:0] echo_len_of(input logic [31:0] len);
    return (len == 32'd0) ? 32'(MAX_ECHO_CYCLES) : len;
  endfunction

  // Stage: trigger synchronizer and fall detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      trig_m <= trigger;
      trig_s <= trig_m;
      trig_d <= trig_s;
    end
  end

  assign trig_fall = trig_d & ~trig_s;
  assign trig_ok   = (trig_cnt >= TRIG_MIN);
  assign dly_done  = (dly_cnt == DLY_LAST);
  assign echo_done = (echo_cnt == shadow_len - 32'd1);
  assign hold_done = (hold_cnt == HOLD_LAST);

  // Stage: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (trig_fall) begin
          if (trig_ok) begin
            accept    = 1'b1;
            state_nxt = DELAY;
          end else begin
            reject    = 1'b1;
          end
        end
      end
      DELAY:   if (dly_done)  state_nxt = ECHO;
      ECHO:    if (echo_done) state_nxt = HOLDOFF;
      HOLDOFF: if (hold_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage: phase counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_cnt <= '0;
      dly_cnt  <= '0;
      echo_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      // Only the part of a pulse seen while IDLE counts toward qualification.
      if (state != IDLE || trig_fall) trig_cnt <= '0;
      else if (trig_s)                trig_cnt <= trig_sat_inc(trig_cnt);

      dly_cnt  <= (state == DELAY   && !dly_done)  ? dly_cnt + DLY_W'(1)   : '0;
      echo_cnt <= (state == ECHO    && !echo_done) ? echo_cnt + 32'd1      : '0;
      hold_cnt <= (state == HOLDOFF && !hold_done) ? hold_cnt + HOLD_W'(1) : '0;
    end
  end

  // Stage: configuration and shadow length
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_echo_len <= 32'(DEFAULT_ECHO);
      shadow_len   <= 32'(DEFAULT_ECHO);
    end else begin
      if (cfg_write) cfg_echo_len <= cfg_data;
      if (accept)    shadow_len   <= echo_len_of(cfg_echo_len);
    end
  end

  // Stage: registered outputs; echo trails the ECHO state by one cycle so the
  // rise lands three edges after trigger is first sampled low plus the burst delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo       <= 1'b0;
      trig_error <= 1'b0;
      echo_count <= 16'd0;
    end else begin
      echo       <= (state == ECHO);
      trig_error <= reject;
      if (echo && state != ECHO) echo_count <= echo_count + 16'd1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ultra_sonic_responder.sv
// Randomized bench for ultra_sonic_responder: trigger pulses and cfg writes checked
// against a transaction-level model of latency, echo width, counters and busy window.
module tb_ultra_sonic_responder;

  localparam int P_MIN  = 8;
  localparam int P_DLY  = 20;
  localparam int P_MAX  = 300;
  localparam int P_HOLD = 50;
  localparam int P_DEF  = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        echo;
  logic        cfg_write = 1'b0;
  logic [31:0] cfg_data = 32'd0;
  logic [31:0] cfg_echo_len;
  logic        busy;
  logic        trig_error;
  logic [15:0] echo_count;

  ultra_sonic_responder #(
    .MIN_TRIG_CYCLES   (P_MIN),
    .BURST_DELAY_CYCLES(P_DLY),
    .MAX_ECHO_CYCLES   (P_MAX),
    .HOLDOFF_CYCLES    (P_HOLD),
    .DEFAULT_ECHO      (P_DEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .echo        (echo),
    .cfg_write   (cfg_write),
    .cfg_data    (cfg_data),
    .cfg_echo_len(cfg_echo_len),
    .busy        (busy),
    .trig_error  (trig_error),
    .echo_count  (echo_count)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Model state
  longint cfg_model = P_DEF;
  longint cnt_model = 0;
  longint idle_edge = 0;

  // Observed event log
  longint rise_q[$];
  longint fall_q[$];
  logic   echo_q = 1'b0;
  logic   terr_q = 1'b0;
  int     terr_cnt = 0;
  int     terr_long = 0;
  int     busy_cnt = 0;

  always @(negedge clk) begin
    if (echo && !echo_q) rise_q.push_back(cyc);
    if (!echo && echo_q) fall_q.push_back(cyc);
    echo_q = echo;
    if (trig_error) terr_cnt++;
    if (trig_error && terr_q) terr_long++;
    terr_q = trig_error;
    if (busy) busy_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive trigger high for exactly t sampling edges; e0 is the first edge sampling low.
  task automatic pulse(input int t, output longint e0);
    @(negedge clk);
    trigger = 1'b1;
    repeat (t) @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
    e0 = cyc + 1;
  endtask

  task automatic wait_evt(input bit want_fall, input int budget, output bit ok, output longint v);
    ok = 1'b0;
    v  = 0;
    for (int i = 0; i < budget; i++) begin
      if (!want_fall && rise_q.size() > 0) begin v = rise_q.pop_front(); ok = 1'b1; break; end
      if (want_fall && fall_q.size() > 0)  begin v = fall_q.pop_front(); ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic cfg_wr(input logic [31:0] v, input string tag);
    @(negedge clk);
    cfg_write = 1'b1;
    cfg_data  = v;
    @(negedge clk);
    cfg_write = 1'b0;
    cfg_model = v;
    chk(tag, cfg_echo_len, v);
  endtask

  task automatic evaluate(input longint e0, input bit acc, input bit retrig,
                          input bit cfg_mid, input bit pre_high);
    int     terr0 = terr_cnt;
    int     busy0 = busy_cnt;
    longint r, f, len, dmy;
    bit     ok;
    if (!acc) begin
      tick(6);
      chk("rej_trig_error", 64'(terr_cnt - terr0), 1);
      chk("rej_err_width", 64'(terr_long), 0);
      chk("rej_busy", 64'(busy_cnt - busy0), 0);
      chk("rej_no_echo", 64'(rise_q.size()), 0);
      return;
    end
    len = (cfg_model == 0) ? P_MAX : cfg_model;
    if (retrig) begin
      tick(3);
      pulse(P_MIN + 2, dmy);
    end
    wait_evt(1'b0, P_DLY + 40, ok, r);
    if (!ok) begin chk("echo_rise_seen", 0, 1); return; end
    chk("echo_latency", r - e0, P_DLY + 3);
    if (cfg_mid) cfg_wr($urandom_range(1, 60), "cfg_mid_write");
    if (retrig) pulse(P_MIN + 1, dmy);
    wait_evt(1'b1, P_MAX + 40, ok, f);
    if (!ok) begin chk("echo_fall_seen", 0, 1); return; end
    chk("echo_width", f - r, len);
    cnt_model++;
    chk("echo_count", echo_count, cnt_model & 16'hFFFF);
    if (pre_high) begin
      while (cyc < f + 3) @(negedge clk);
      trigger = 1'b1;
    end
    while (cyc < f + P_HOLD - 2) @(negedge clk);
    chk("busy_in_holdoff", busy, 1);
    @(negedge clk);
    chk("busy_after_holdoff", busy, 0);
    idle_edge = cyc;
    chk("ignored_trig_error", 64'(terr_cnt - terr0), 0);
  endtask

  task automatic do_trans(input int t, input bit retrig, input bit cfg_mid, input bit pre_high);
    longint e0;
    pulse(t, e0);
    evaluate(e0, t >= P_MIN, retrig, cfg_mid, pre_high);
  endtask

  // Trigger already high on IDLE entry: release so the IDLE portion is k cycles.
  task automatic idle_pulse(input int k);
    longint e0;
    while (cyc < idle_edge + k - 2) @(negedge clk);
    trigger = 1'b0;
    e0 = cyc + 1;
    evaluate(e0, k >= P_MIN, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    longint r;
    bit     ok;
    longint e0;
    int     t;

    tick(3);
    #1;
    chk("rst_echo", echo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trig_error", trig_error, 0);
    chk("rst_echo_count", echo_count, 0);
    chk("rst_cfg", cfg_echo_len, P_DEF);
    @(negedge clk);
    reset = 1'b0;
    tick(2);

    do_trans(P_MIN, 1'b0, 1'b0, 1'b0);
    do_trans(P_MIN - 1, 1'b0, 1'b0, 1'b0);
    do_trans(P_MIN + 3, 1'b1, 1'b1, 1'b0);
    do_trans(P_MIN, 1'b0, 1'b0, 1'b0);
    cfg_wr(32'd0, "cfg_zero_write");
    do_trans(P_MIN + 2, 1'b0, 1'b0, 1'b0);
    cfg_wr(32'd1, "cfg_one_write");
    do_trans(P_MIN, 1'b1, 1'b0, 1'b0);
    cfg_wr(32'd25, "cfg_write");
    do_trans(P_MIN, 1'b0, 1'b0, 1'b1);
    idle_pulse(P_MIN - 1);
    do_trans(P_MIN, 1'b0, 1'b0, 1'b1);
    idle_pulse(P_MIN);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_wr(($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 60)), "cfg_rand_write");
      t = $urandom_range(P_MIN - 3, P_MIN + 4);
      do_trans(t, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'b0);
    end

    // Reset in the middle of an echo
    cfg_wr(32'd100, "cfg_pre_reset");
    pulse(P_MIN, e0);
    wait_evt(1'b0, P_DLY + 40, ok, r);
    chk("rst_mid_rise_seen", ok, 1);
    tick(10);
    chk("rst_mid_echo_high", echo, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_echo", echo, 0);
    chk("rst_mid_echo_count", echo_count, 0);
    chk("rst_mid_cfg", cfg_echo_len, P_DEF);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    rise_q.delete();
    fall_q.delete();
    cnt_model = 0;
    cfg_model = P_DEF;
    do_trans(P_MIN, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
